// File: rtl/checker_arbiter.sv
// checker_arbiter: shares one begin/end block checker between two character
// streams. A requester is granted a whole '.'-terminated sentence; the checker
// is reset for one cycle, fed the characters gap-free, flushed with a space,
// and its verdict is reported tagged with the requester id.
module checker_arbiter #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic [7:0] chk_in,
  output logic       chk_reset,
  input  logic       chk_result,
  output logic       busy,
  output logic       done_valid,
  output logic       done_id,
  output logic       done_result,
  output logic       done_err
);

  localparam int            CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LEN);
  localparam logic [7:0]    SPACE   = 8'h20;
  localparam logic [7:0]    DOT     = 8'h2E;

  typedef enum logic [2:0] {
    IDLE,
    RST,
    STREAM,
    FLUSH,
    SAMPLE
  } state_t;

  state_t        state, state_next;
  logic          gnt, gnt_next;
  logic          last_gnt, last_gnt_next;
  logic          chk_reset_q, chk_reset_next;
  logic [7:0]    chk_in_next;
  logic [CW-1:0] len, len_next;
  logic          done_valid_next, done_id_next, done_result_next, done_err_next;

  logic          winner;
  logic          gnt_valid;
  logic [7:0]    gnt_data;

  // On a tie the requester that did not win last time gets the grant.
  assign winner    = (req0_valid && req1_valid) ? !last_gnt : req1_valid;
  assign gnt_valid = gnt ? req1_valid : req0_valid;
  assign gnt_data  = gnt ? req1_data  : req0_data;

  // Handshake and status are forced quiet while reset is asserted.
  assign req0_ready = reset && (state == STREAM) && !gnt;
  assign req1_ready = reset && (state == STREAM) &&  gnt;
  assign busy       = reset && (state != IDLE);
  assign chk_reset  = chk_reset_q || !reset;

  // Next-state and next-register values for the sentence sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path can infer a latch.
    state_next       = state;
    gnt_next         = gnt;
    last_gnt_next    = last_gnt;
    chk_reset_next   = 1'b0;
    chk_in_next      = SPACE;
    len_next         = len;
    done_valid_next  = 1'b0;
    done_id_next     = done_id;
    done_result_next = done_result;
    done_err_next    = done_err;

    case (state)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          gnt_next       = winner;
          last_gnt_next  = winner;
          chk_reset_next = 1'b1;
          len_next       = '0;
          state_next     = RST;
        end
      end
      RST: state_next = STREAM;
      STREAM: begin
        if (gnt_valid && (gnt_data == DOT)) begin
          state_next = FLUSH;
        end else if (gnt_valid && (len != MAX_CNT)) begin
          chk_in_next = gnt_data;
          len_next    = len + 1'b1;
        end else begin
          // Bubble or overlength: the checker cannot pause, so give up.
          done_valid_next  = 1'b1;
          done_err_next    = 1'b1;
          done_result_next = 1'b0;
          done_id_next     = gnt;
          state_next       = IDLE;
        end
      end
      FLUSH: state_next = SAMPLE;
      SAMPLE: begin
        done_valid_next  = 1'b1;
        done_err_next    = 1'b0;
        done_result_next = chk_result;
        done_id_next     = gnt;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      chk_reset_q <= 1'b0;
      chk_in      <= SPACE;
      len         <= '0;
      done_valid  <= 1'b0;
      done_id     <= 1'b0;
      done_result <= 1'b0;
      done_err    <= 1'b0;
    end else begin
      state       <= state_next;
      gnt         <= gnt_next;
      last_gnt    <= last_gnt_next;
      chk_reset_q <= chk_reset_next;
      chk_in      <= chk_in_next;
      len         <= len_next;
      done_valid  <= done_valid_next;
      done_id     <= done_id_next;
      done_result <= done_result_next;
      done_err    <= done_err_next;
    end
  end

endmodule

// File: tb/tb_checker_arbiter.sv
// Scoreboard bench for checker_arbiter: two DUTs (default MAX_LEN and
// MAX_LEN=4), each driving a behavioural begin/end checker peer.
module tb_checker_arbiter;

  localparam logic [8:0] BUBBLE = 9'h100;

  typedef struct packed {
    logic id;
    logic res;
    logic err;
  } exp_t;

  typedef struct packed {
    logic [39:0] sh;
    logic [2:0]  len;
    logic [7:0]  depth;
    logic        bad;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] v;
  logic [7:0] d [3];
  wire        r0_rdy, r1_rdy, r4_rdy, d4_r1_rdy;
  wire  [2:0] rdy = {r4_rdy, r1_rdy, r0_rdy};
  logic       tie0;
  logic [7:0] tie0_data;

  wire  [7:0] chk_in, d4_chk_in;
  wire        chk_reset, d4_chk_reset;
  wire        busy, d4_busy;
  wire        done_valid, done_id, done_result, done_err;
  wire        d4_done_valid, d4_done_id, d4_done_result, d4_done_err;

  chk_t m0 = '0, m4 = '0;
  wire  res0 = !m0.bad && (m0.depth == 8'd0);
  wire  res4 = !m4.bad && (m4.depth == 8'd0);

  logic [8:0] rq [3][$];
  exp_t exp_q[$], exp4_q[$];
  exp_t e0, e4;

  int cyc = 0;
  int n_pass = 0, n_total = 0;
  int done_cnt = 0, last_done_cyc = 0, prev_done_cyc = 0;
  int done4_cnt = 0, last_done4_cyc = 0;
  logic last_done_busy = 1'b0;

  checker_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(v[0]), .req0_data(d[0]), .req0_ready(r0_rdy),
    .req1_valid(v[1]), .req1_data(d[1]), .req1_ready(r1_rdy),
    .chk_in(chk_in), .chk_reset(chk_reset), .chk_result(res0),
    .busy(busy), .done_valid(done_valid), .done_id(done_id),
    .done_result(done_result), .done_err(done_err)
  );

  checker_arbiter #(.MAX_LEN(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0_valid(v[2]), .req0_data(d[2]), .req0_ready(r4_rdy),
    .req1_valid(tie0), .req1_data(tie0_data), .req1_ready(d4_r1_rdy),
    .chk_in(d4_chk_in), .chk_reset(d4_chk_reset), .chk_result(res4),
    .busy(d4_busy), .done_valid(d4_done_valid), .done_id(d4_done_id),
    .done_result(d4_done_result), .done_err(d4_done_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Begin/end checker peer: words end at a space; "end" without an open
  // "begin" is a permanent error; balanced means no error and depth zero.
  function automatic chk_t chk_step(input chk_t s, input logic [7:0] c);
    chk_t n = s;
    if (c == 8'h20) begin
      if (s.len == 3'd5 && s.sh == "begin") n.depth = s.depth + 8'd1;
      else if (s.len == 3'd3 && s.sh[23:0] == "end") begin
        if (s.depth == 8'd0) n.bad = 1'b1;
        else n.depth = s.depth - 8'd1;
      end
      n.len = 3'd0;
      n.sh  = '0;
    end else begin
      n.sh = {s.sh[31:0], c};
      if (s.len < 3'd6) n.len = s.len + 3'd1;
    end
    return n;
  endfunction

  always @(posedge clk) m0 <= chk_reset    ? '0 : chk_step(m0, chk_in);
  always @(posedge clk) m4 <= d4_chk_reset ? '0 : chk_step(m4, d4_chk_in);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic exp_t mk(input logic id, input logic res, input logic err);
    return '{id: id, res: res, err: err};
  endfunction

  task automatic at_neg();
    @(negedge clk);
    #2;
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input string s);
    for (int k = 0; k < s.len(); k++) rq[i].push_back({1'b0, s[k]});
  endtask

  task automatic wait_done(input int target);
    int b = 0;
    while (done_cnt < target && b < 300) begin at_neg(); b++; end
    check("wait_done", done_cnt, target);
  endtask

  task automatic wait_done4(input int target);
    int b = 0;
    while (done4_cnt < target && b < 300) begin at_neg(); b++; end
    check("wait_done4", done4_cnt, target);
  endtask

  // Requester models: present the queue head each cycle, pop on acceptance.
  initial begin
    logic [8:0] h;
    v = '0;
    for (int i = 0; i < 3; i++) d[i] = 8'h00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rq[i].size() == 0) v[i] = 1'b0;
        else begin
          h = rq[i][0];
          if (h == BUBBLE) begin v[i] = 1'b0; void'(rq[i].pop_front()); end
          else begin v[i] = 1'b1; d[i] = h[7:0]; end
        end
      end
      #1;
      for (int i = 0; i < 3; i++)
        if (v[i] && rdy[i]) void'(rq[i].pop_front());
    end
  end

  // Monitor: pop and compare the expected outcome whenever a DUT reports one.
  always @(negedge clk) begin
    #3;
    if (done_valid) begin
      if (exp_q.size() == 0) check("sb0_unexpected_done", 1, 0);
      else begin
        e0 = exp_q.pop_front();
        check("sb0_id", done_id, e0.id);
        check("sb0_result", done_result, e0.res);
        check("sb0_err", done_err, e0.err);
      end
      prev_done_cyc  = last_done_cyc;
      last_done_cyc  = cyc;
      last_done_busy = busy;
      done_cnt++;
    end
    if (d4_done_valid) begin
      if (exp4_q.size() == 0) check("sb4_unexpected_done", 1, 0);
      else begin
        e4 = exp4_q.pop_front();
        check("sb4_id", d4_done_id, e4.id);
        check("sb4_result", d4_done_result, e4.res);
        check("sb4_err", d4_done_err, e4.err);
      end
      last_done4_cyc = cyc;
      done4_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int c0;
    logic [14:0] m_rst, m_busy, m_rdy;
    logic r1_seen;
    int b;
    reset = 1'b0;
    tie0 = 1'b0;
    tie0_data = 8'h00;

    // Reset values.
    repeat (2) @(posedge clk);
    at_neg();
    check("rst_chk_reset", chk_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_readies", {r1_rdy, r0_rdy}, 0);
    check("rst_chk_in", chk_in, 8'h20);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_fields", {done_id, done_result, done_err}, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) at_neg();
    check("idle_chk_reset", chk_reset, 0);

    // T1: balanced sentence from requester 0, cycle-exact.
    sync();
    load(0, "begin end.");
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    c0 = cyc;
    for (int i = 0; i < 15; i++) begin
      at_neg();
      m_rst[i]  = chk_reset;
      m_busy[i] = busy;
      m_rdy[i]  = r0_rdy;
      if (i == 3)  check("t1_first_char", chk_in, 8'h62);
      if (i == 12) check("t1_flush_space", chk_in, 8'h20);
    end
    check("t1_chk_reset_mask", m_rst, 15'h0002);
    check("t1_busy_mask", m_busy, 15'h3FFE);
    check("t1_ready_mask", m_rdy, 15'h0FFC);
    wait_done(1);
    check("t1_done_cycle", last_done_cyc - c0, 14);

    // T2: premature end from requester 1.
    sync();
    load(1, "end begin.");
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
    c0 = cyc;
    wait_done(2);
    check("t2_done_cycle", last_done_cyc - c0, 14);

    // T3: tie at reset release, then fairness.
    @(negedge clk) reset = 1'b0;
    load(0, "begin end.");
    load(1, "begin end.");
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0));
    repeat (2) at_neg();
    @(negedge clk) reset = 1'b1;
    r1_seen = 1'b0;
    b = 0;
    while (done_cnt < 3 && b < 100) begin at_neg(); r1_seen |= r1_rdy; b++; end
    check("t3_r1_ready_during_s0", r1_seen, 0);
    wait_done(4);
    check("t3_back_to_back", last_done_cyc - prev_done_cyc, 14);

    // T4: bubble after "beg", then a lone '.' as a new sentence.
    sync();
    load(0, "beg");
    rq[0].push_back(BUBBLE);
    load(0, ".");
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    c0 = cyc;
    wait_done(5);
    check("t4_abort_cycle", last_done_cyc - c0, 6);
    check("t4_idle_at_abort", last_done_busy, 0);
    wait_done(6);
    check("t4_resume_cycle", last_done_cyc - c0, 11);

    // T5: overlength on the MAX_LEN=4 instance.
    sync();
    load(2, "begin.");
    exp4_q.push_back(mk(1'b0, 1'b0, 1'b1));
    exp4_q.push_back(mk(1'b0, 1'b1, 1'b0));
    c0 = cyc;
    wait_done4(1);
    check("t5_abort_cycle", last_done4_cyc - c0, 7);
    wait_done4(2);
    check("t5_empty_cycle", last_done4_cyc - c0, 12);
    check("t5_all_consumed", rq[2].size(), 0);
    check("t5_r1_ready_idle", d4_r1_rdy, 0);

    // T6: reset mid-stream, then requester 0 wins the tie.
    sync();
    load(0, "xyz begin end.");
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0));
    c0 = cyc;
    repeat (3) at_neg();
    load(1, "end begin.");
    repeat (2) at_neg();
    @(negedge clk) reset = 1'b0;
    #2;
    check("t6_chk_reset_in_reset", chk_reset, 1);
    check("t6_busy_in_reset", busy, 0);
    check("t6_readies_in_reset", {r1_rdy, r0_rdy}, 0);
    @(negedge clk) reset = 1'b1;
    #2;
    check("t6_busy_after", busy, 0);
    check("t6_readies_after", {r1_rdy, r0_rdy}, 0);
    check("t6_chk_in_after", chk_in, 8'h20);
    check("t6_no_done", done_valid, 0);
    wait_done(8);

    repeat (3) at_neg();
    check("end_exp_q_empty", exp_q.size(), 0);
    check("end_exp4_q_empty", exp4_q.size(), 0);
    check("end_req_queues_empty", rq[0].size() + rq[1].size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
